rv_instr_encoder: RTL and testbench
===================================

# rv_instr_encoder

Sequential RV32I instruction encoder: the inverse of the instruction decoder. It accepts symbolic operation requests (op, rd, rs1, rs2, imm) through a valid/ready handshake and emits 32-bit machine words, each tagged with a sequential word address, to a program-memory loader. It covers the same instruction subset the decoder recognises: add, addi, beq, bne, blt, bge, bltu, bgeu. It sits between the test/boot sequencer and the instruction memory write port.

## Interface
- ADDR_W, 8, width of the word-address counter; 2^ADDR_W words of program space.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- op  in  3  0 add, 1 addi, 2 beq, 3 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu.
- rd, rs1, rs2  in  5 each  register indices; fields unused by an op are ignored.
- imm  in  32  signed immediate; for addi a value, for branches a byte offset.
- restart  in  1  synchronous clear of the address counter, full and err.
- out_valid  out  1  encoded word present.
- out_ready  in  1  word consumed when out_valid && out_ready.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_instr.
- full  out  1  address space exhausted; sticky until restart or rst.
- err  out  1  sticky; a request was rejected.

## Operation
- Encoding formats:
  - add uses R-type: {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}.
  - addi uses I-type: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}. Legal only for -2048 <= imm <= 2047.
  - Branches use B-type: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011}.
  - Branch f3 values: beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111.
  - A branch is legal only when imm[0] == 0 and -4096 <= imm <= 4094.
- Output register holds one word; it is an implicit two-state FSM:
  - EMPTY (out_valid = 0).
  - HOLD (out_valid = 1).
- in_ready = (!out_valid || out_ready) && !full && !restart.
- Accepted legal request:
  - Load out_instr and out_addr = addr_cnt.
  - Set out_valid.
  - addr_cnt += 1.
- Accepted illegal request:
  - Consumed with no output and no addr_cnt change.
  - err <= 1.
- Wrap-around: an accepted legal request while addr_cnt == 2^ADDR_W-1 sets full and wraps addr_cnt to 0. No further requests are accepted while full.
- Restart:
  - Clears addr_cnt, full and err.
  - Does not disturb a word already held; it still drains normally.
  - Restart has priority over acceptance in the same cycle.
- Simultaneous drain and accept: a new word replaces the old one in the same edge, so back-to-back throughput is one word per cycle.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr 0, full 0, err 0, addr_cnt 0. in_ready is 1 after reset.
- Latency: a request accepted at edge N is visible at out_* after edge N.
- out_instr and out_addr are stable while out_valid && !out_ready.
- in_ready is combinational from out_valid, out_ready, full and restart. There is no combinational path from in_valid to out_*.
- err sets on the edge of the rejected acceptance.
- Reset asserted mid-operation discards the held word immediately; out_valid falls asynchronously.

## Test plan
- addi: op=1, rd=6, rs1=7, imm=33 -> out_instr 0x02138313, out_addr 0, err 0.
- add, then beq, back-to-back with out_ready=1:
  - Request add x3,x1,x2 -> 0x002081B3 at addr 0.
  - Next cycle, request beq x1,x2,imm=-8 -> 0xFE208CE3 at addr 1.
- Illegal requests:
  - addi with imm=2048 -> no out_valid, err=1, addr_cnt unchanged.
  - Then beq with imm=3 -> still no output.
  - Then a legal add -> emitted at addr 0.
- Backpressure: hold out_ready=0 after one accepted word.
  - in_ready=0 and out_* stay constant for 5 cycles.
  - Raise out_ready with in_valid high -> drain and accept occur on the same edge.
- Wrap: with ADDR_W=2, issue four legal requests.
  - Addresses are 0,1,2,3; full=1 after the fourth; in_ready=0.
  - Pulse restart -> full=0, err=0, and the next word is at addr 0.
- Reset: assert rst with out_valid=1 and out_ready=0 -> all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: turns symbolic RV32I requests (add, addi, branches) into
// 32-bit machine words tagged with a sequential word address.
`default_nettype none

module rv_instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              restart,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic [31:0] enc_instr;
  logic        enc_legal;
  logic [2:0]  br_f3;
  logic        i_imm_ok;
  logic        b_imm_ok;
  logic        accept;

  assign out_valid = (state_q == HOLD);
  assign out_instr = instr_q;
  assign out_addr  = oaddr_q;
  assign full      = full_q;
  assign err       = err_q;

  assign in_ready = (!out_valid || out_ready) && !full_q && !restart;
  assign accept   = in_valid && in_ready;

  // Immediate fits when all bits above the field's sign bit replicate it.
  assign i_imm_ok = (imm[31:11] == {21{imm[31]}});
  assign b_imm_ok = (imm[31:12] == {20{imm[31]}}) && !imm[0];
  // beq/bne map to f3 000/001; ops 4..7 already equal their f3 codes.
  assign br_f3    = op[2] ? op : {2'b00, op[0]};

  always_comb begin
    enc_instr = '0;
    enc_legal = 1'b0;
    case (op)
      3'd0: begin
        enc_instr = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
        enc_legal = 1'b1;
      end
      3'd1: begin
        enc_instr = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
        enc_legal = i_imm_ok;
      end
      default: begin
        enc_instr = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], 7'b1100011};
        enc_legal = b_imm_ok;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    oaddr_d = oaddr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    err_d   = err_q;

    if (accept && enc_legal) begin
      state_d = HOLD;
      instr_d = enc_instr;
      oaddr_d = cnt_q;
    end else if (out_valid && out_ready) begin
      state_d = EMPTY;
    end

    // Restart never coincides with acceptance because it forces in_ready low.
    if (restart) begin
      cnt_d  = '0;
      full_d = 1'b0;
      err_d  = 1'b0;
    end else if (accept) begin
      if (enc_legal) begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          full_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      instr_q <= '0;
      oaddr_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      oaddr_q <= oaddr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_instr_encoder.sv
// Testbench for rv_instr_encoder: table of single-request encodings plus
// hand-written handshake, wrap, restart and reset sequences.
`default_nettype none

module tb_rv_instr_encoder;

  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        op = '0;
  logic [4:0]        rd = '0;
  logic [4:0]        rs1 = '0;
  logic [4:0]        rs2 = '0;
  logic [31:0]       imm = '0;
  logic              restart = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              full;
  logic              err;

  int nchecks = 0;
  int nerr = 0;

  rv_instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .restart(restart),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] instr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    in_valid = 1'b1;
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic do_restart();
    in_valid = 1'b0;
    restart = 1'b1;
    out_ready = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 5'd6,  5'd7,  5'd0,  32'd33,         1'b1, 32'h02138313};
    vecs[1]  = '{3'd0, 5'd3,  5'd1,  5'd2,  32'd0,          1'b1, 32'h002081B3};
    vecs[2]  = '{3'd2, 5'd0,  5'd1,  5'd2,  -32'sd8,        1'b1, 32'hFE208CE3};
    vecs[3]  = '{3'd3, 5'd0,  5'd5,  5'd6,  32'd16,         1'b1, 32'h00629863};
    vecs[4]  = '{3'd4, 5'd0,  5'd1,  5'd2,  32'd4094,       1'b1, 32'h7E20CFE3};
    vecs[5]  = '{3'd5, 5'd0,  5'd0,  5'd0,  -32'sd4096,     1'b1, 32'h80005063};
    vecs[6]  = '{3'd6, 5'd0,  5'd3,  5'd4,  32'd2,          1'b1, 32'h0041E163};
    vecs[7]  = '{3'd7, 5'd0,  5'd31, 5'd30, -32'sd2,        1'b1, 32'hFFEFFFE3};
    vecs[8]  = '{3'd1, 5'd1,  5'd0,  5'd0,  -32'sd2048,     1'b1, 32'h80000093};
    vecs[9]  = '{3'd1, 5'd2,  5'd2,  5'd0,  32'd2047,       1'b1, 32'h7FF10113};
    vecs[10] = '{3'd1, 5'd2,  5'd2,  5'd0,  -32'sd2049,     1'b0, 32'h0};
    vecs[11] = '{3'd2, 5'd0,  5'd1,  5'd2,  32'd4096,       1'b0, 32'h0};
    vecs[12] = '{3'd3, 5'd0,  5'd1,  5'd2,  32'd1,          1'b0, 32'h0};
    vecs[13] = '{3'd4, 5'd0,  5'd1,  5'd2,  -32'sd4098,     1'b0, 32'h0};

    // Reset state
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", {30'b0, out_addr}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    step();

    // Single-request encodings
    for (int i = 0; i < NV; i++) begin
      do_restart();
      drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].legal});
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, !vecs[i].legal});
      if (vecs[i].legal) begin
        chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].instr);
        chk($sformatf("vec%0d_addr", i), {30'b0, out_addr}, 32'd0);
      end
    end

    // Back-to-back add then beq
    do_restart();
    drive(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    chk("b2b_add_instr", out_instr, 32'h002081B3);
    chk("b2b_add_addr", {30'b0, out_addr}, 32'd0);
    drive(3'd2, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8);
    step();
    in_valid = 1'b0;
    chk("b2b_beq_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_beq_instr", out_instr, 32'hFE208CE3);
    chk("b2b_beq_addr", {30'b0, out_addr}, 32'd1);
    step();
    chk("b2b_drained", {31'b0, out_valid}, 32'd0);

    // Illegal requests leave the counter alone
    do_restart();
    drive(3'd1, 5'd1, 5'd1, 5'd0, 32'd2048);
    step();
    chk("ill_addi_valid", {31'b0, out_valid}, 32'd0);
    chk("ill_addi_err", {31'b0, err}, 32'd1);
    drive(3'd2, 5'd0, 5'd1, 5'd2, 32'd3);
    step();
    chk("ill_beq_valid", {31'b0, out_valid}, 32'd0);
    drive(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    in_valid = 1'b0;
    chk("ill_then_add_valid", {31'b0, out_valid}, 32'd1);
    chk("ill_then_add_addr", {30'b0, out_addr}, 32'd0);
    chk("ill_err_sticky", {31'b0, err}, 32'd1);
    step();

    // Backpressure: hold, then drain and accept on one edge
    do_restart();
    out_ready = 1'b0;
    drive(3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    chk("bp_first_valid", {31'b0, out_valid}, 32'd1);
    drive(3'd1, 5'd6, 5'd7, 5'd0, 32'd33);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp_in_ready_c%0d", c), {31'b0, in_ready}, 32'd0);
      chk($sformatf("bp_instr_c%0d", c), out_instr, 32'h002081B3);
      chk($sformatf("bp_addr_c%0d", c), {30'b0, out_addr}, 32'd0);
      chk($sformatf("bp_valid_c%0d", c), {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_new_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_new_instr", out_instr, 32'h02138313);
    chk("bp_new_addr", {30'b0, out_addr}, 32'd1);
    step();

    // Wrap-around with a 2-bit counter
    do_restart();
    for (int i = 0; i < 4; i++) begin
      drive(3'd0, 5'(i + 1), 5'd0, 5'd0, 32'd0);
      step();
      chk($sformatf("wrap_addr%0d", i), {30'b0, out_addr}, i);
      chk($sformatf("wrap_instr%0d", i), out_instr, (32'(i + 1) << 7) | 32'h33);
    end
    in_valid = 1'b0;
    #1;
    chk("wrap_full", {31'b0, full}, 32'd1);
    chk("wrap_in_ready", {31'b0, in_ready}, 32'd0);
    drive(3'd0, 5'd9, 5'd0, 5'd0, 32'd0);
    step();
    in_valid = 1'b0;
    chk("wrap_no_accept", {31'b0, out_valid}, 32'd0);
    chk("wrap_full_sticky", {31'b0, full}, 32'd1);
    restart = 1'b1;
    #1;
    chk("restart_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    restart = 1'b0;
    chk("restart_full", {31'b0, full}, 32'd0);
    chk("restart_err", {31'b0, err}, 32'd0);
    drive(3'd0, 5'd4, 5'd0, 5'd0, 32'd0);
    step();
    in_valid = 1'b0;
    chk("restart_next_addr", {30'b0, out_addr}, 32'd0);
    chk("restart_next_valid", {31'b0, out_valid}, 32'd1);

    // Restart does not disturb a held word
    out_ready = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_hold_valid", {31'b0, out_valid}, 32'd1);
    chk("restart_hold_instr", out_instr, 32'h00000233);

    // Asynchronous reset with a held word
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    chk("arst_out_addr", {30'b0, out_addr}, 32'd0);
    chk("arst_full", {31'b0, full}, 32'd0);
    chk("arst_err", {31'b0, err}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

`default_nettype wire
